// File: rtl/road_stream_player.sv
// road_stream_player: four-plane road word store replayed as gapped dv beats with an end-of-run pulse
module road_stream_player #(
  parameter int DATA_W = 30,
  parameter int DEPTH  = 256,
  parameter int AW     = 8,
  parameter int GAP_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_en,
  input  logic [1:0]        load_plane,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_full,
  input  logic              clear,
  input  logic              start,
  input  logic [GAP_W-1:0]  gap,
  output logic              busy,
  output logic [DATA_W-1:0] p0_road_data,
  output logic              p0_road_dv,
  output logic [DATA_W-1:0] p1_road_data,
  output logic              p1_road_dv,
  output logic [DATA_W-1:0] p2_road_data,
  output logic              p2_road_dv,
  output logic [DATA_W-1:0] p3_road_data,
  output logic              p3_road_dv,
  output logic              eor
);
  typedef enum logic [1:0] {IDLE, PLAY, EOR} state_t;
  state_t state, state_n;
  logic [DATA_W-1:0] mem [4][DEPTH];
  logic [DATA_W-1:0] rdat [4];
  logic [DATA_W-1:0] dat [4];
  logic [AW:0] cnt [4];
  logic [AW:0] rd [4];
  logic [GAP_W-1:0] gap_q, gap_cnt;
  logic [3:0] pend, act, dv;
  logic idle, issue, wr;
  assign idle      = state == IDLE;
  assign issue     = state == PLAY && gap_cnt == '0;
  assign load_full = cnt[load_plane] == (AW+1)'(DEPTH);
  assign wr        = idle && !clear && load_en && !load_full;
  assign busy      = state != IDLE;
  assign {p3_road_dv, p2_road_dv, p1_road_dv, p0_road_dv} = dv;
  assign p0_road_data = dat[0];
  assign p1_road_data = dat[1];
  assign p2_road_data = dat[2];
  assign p3_road_data = dat[3];
  // a plane is pending while it still has unread words
  always_comb begin
    for (int p = 0; p < 4; p++) pend[p] = rd[p] < cnt[p];
  end
  // run ends once every plane is drained; EOR lasts one cycle
  always_comb begin
    state_n = state;
    state_n = idle ? (start ? PLAY : IDLE) : state == PLAY ? (|pend ? PLAY : EOR) : IDLE;
  end
  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_n;
  end
  // plane RAMs: writes append at the count, reads fetch the beat word
  always_ff @(posedge clk) begin
    if (wr) mem[load_plane][cnt[load_plane][AW-1:0]] <= load_data;
    for (int p = 0; p < 4; p++)
      if (issue) rdat[p] <= mem[p][rd[p][AW-1:0]];
  end
  // counts, read pointers, gap timer and the two-stage beat pipeline
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int p = 0; p < 4; p++) begin
        cnt[p] <= '0;
        rd[p]  <= '0;
        dat[p] <= '0;
      end
      gap_q   <= '0;
      gap_cnt <= '0;
      act     <= '0;
      dv      <= '0;
      eor     <= 1'b0;
    end else begin
      for (int p = 0; p < 4; p++) begin
        if (idle && clear) cnt[p] <= '0;
        else if (wr && load_plane == 2'(p)) cnt[p] <= cnt[p] + (AW+1)'(1);
        if (idle && start) rd[p] <= '0;
        else if (issue) rd[p] <= rd[p] + (AW+1)'(pend[p]);
        dat[p] <= act[p] ? rdat[p] : dat[p];
      end
      if (idle && start) begin
        gap_q   <= gap;
        gap_cnt <= '0;
      end else if (issue) gap_cnt <= gap_q;
      else if (state == PLAY) gap_cnt <= gap_cnt - GAP_W'(1);
      act <= issue ? pend : '0;
      dv  <= act;
      eor <= state == EOR;
    end
  end
endmodule

// File: tb/tb_road_stream_player.sv
// tb_road_stream_player: random and directed replay checks against a queue-based model
module tb_road_stream_player;
  logic        clk = 0, rst = 1;
  logic        load_en = 0, clear = 0, start = 0;
  logic [1:0]  load_plane = 0;
  logic [29:0] load_data = 0;
  logic [3:0]  gap = 0;
  logic        load_full, busy, eor;
  logic [29:0] pd [4];
  logic [3:0]  pv;
  int vecs = 0, errs = 0;
  logic [29:0] q [4][$];
  logic [29:0] last [4];

  road_stream_player dut (
    .clk(clk), .rst(rst), .load_en(load_en), .load_plane(load_plane), .load_data(load_data),
    .load_full(load_full), .clear(clear), .start(start), .gap(gap), .busy(busy),
    .p0_road_data(pd[0]), .p0_road_dv(pv[0]), .p1_road_data(pd[1]), .p1_road_dv(pv[1]),
    .p2_road_data(pd[2]), .p2_road_dv(pv[2]), .p3_road_data(pd[3]), .p3_road_dv(pv[3]),
    .eor(eor)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int p, input logic [29:0] d);
    load_en = 1; load_plane = 2'(p); load_data = d;
    tick();
    load_en = 0;
    if (q[p].size() < 256) q[p].push_back(d);
    check("full", 32'(load_full), 32'(q[p].size() == 256));
  endtask

  task automatic do_clear();
    clear = 1;
    tick();
    clear = 0;
    for (int p = 0; p < 4; p++) q[p].delete();
  endtask

  task automatic load_t1();
    do_clear();
    load(0, 30'h1); load(0, 30'h2); load(0, 30'h3);
    load(2, 30'h3FFFFFFF);
  endtask

  // replay with gap g; junk pokes control inputs while busy; abort_c>0 resets at that cycle
  task automatic run(input int g, input bit junk, input int abort_c);
    int maxlen, eor_c, b;
    bit hit;
    logic [3:0] edv;
    maxlen = 0;
    for (int p = 0; p < 4; p++) if (q[p].size() > maxlen) maxlen = q[p].size();
    eor_c = (maxlen == 0) ? 2 : 2 + (maxlen - 1) * (g + 1) + 1;
    start = 1; gap = 4'(g);
    tick();
    start = 0;
    for (int c = 1; c <= eor_c + 1; c++) begin
      if (junk && c <= eor_c - 1) begin
        start = 1'($urandom_range(0, 1)); load_en = 1'($urandom_range(0, 1));
        clear = 1'($urandom_range(0, 1)); load_plane = 2'($urandom_range(0, 3));
        load_data = 30'($urandom); gap = 4'($urandom);
      end else begin
        start = 0; load_en = 0; clear = 0;
      end
      tick();
      hit = c >= 2 && (c - 2) % (g + 1) == 0 && (c - 2) / (g + 1) < maxlen;
      b = hit ? (c - 2) / (g + 1) : 0;
      edv = '0;
      for (int p = 0; p < 4; p++)
        if (hit && b < q[p].size()) begin
          edv[p] = 1;
          last[p] = q[p][b];
        end
      check("dv", 32'(pv), 32'(edv));
      for (int p = 0; p < 4; p++) check($sformatf("data%0d", p), 32'(pd[p]), 32'(last[p]));
      check("eor", 32'(eor), 32'(c == eor_c));
      if (c <= eor_c - 1) check("busy", 32'(busy), 1);
      if (c == eor_c + 1) check("idle", 32'(busy), 0);
      if (c == abort_c) begin
        rst = 1;
        #1;
        check("rst_dv", 32'(pv), 0);
        check("rst_eor", 32'(eor), 0);
        check("rst_busy", 32'(busy), 0);
        tick();
        rst = 0;
        for (int p = 0; p < 4; p++) begin
          q[p].delete();
          last[p] = '0;
        end
        return;
      end
    end
  endtask

  initial begin
    for (int p = 0; p < 4; p++) last[p] = '0;
    tick(); tick();
    check("rst_dv", 32'(pv), 0);
    check("rst_eor", 32'(eor), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_full", 32'(load_full), 0);
    for (int p = 0; p < 4; p++) check("rst_data", 32'(pd[p]), 0);
    rst = 0;
    tick();
    load_t1();
    run(0, 0, 0);
    run(2, 0, 0);
    run(0, 1, 0);
    run(0, 1, 0);
    do_clear();
    for (int i = 0; i < 257; i++) load(1, 30'($urandom));
    run(0, 0, 0);
    do_clear();
    run(3, 0, 0);
    load_t1();
    run(0, 0, 3);
    run(0, 0, 0);
    for (int it = 0; it < 12; it++) begin
      if ($urandom_range(0, 1) == 1) do_clear();
      for (int n = $urandom_range(0, 10); n > 0; n--) load($urandom_range(0, 3), 30'($urandom));
      run($urandom_range(0, 15), 1'($urandom_range(0, 1)), 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
